// File: rtl/vred_pkg.sv
// Shared definitions for the reduction feed sequencer.
// Contents: op/SEW/state enums, elements-per-beat helper, identity-value and
// scalar-seed extension helpers. No ports.
package vred_pkg;

  typedef enum logic [1:0] {
    OP_SUM  = 2'b00,
    OP_MAX  = 2'b01,
    OP_MIN  = 2'b10,
    OP_MAXU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  function automatic logic [3:0] epb(input logic [1:0] sew);
    case (sew_e'(sew))
      SEW_8:   return 4'd8;
      SEW_16:  return 4'd4;
      SEW_32:  return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op_e'(op) == OP_MAX) || (op_e'(op) == OP_MIN);
  endfunction

  // Identity value occupying the low SEW bits; upper bits are zero.
  function automatic logic [63:0] identity(input logic [1:0] op, input logic [1:0] sew);
    logic [63:0] msb;
    case (sew_e'(sew))
      SEW_8:   msb = 64'h80;
      SEW_16:  msb = 64'h8000;
      SEW_32:  msb = 64'h8000_0000;
      default: msb = 64'h8000_0000_0000_0000;
    endcase
    case (op_e'(op))
      OP_MAX:  return msb;
      OP_MIN:  return msb - 64'd1;
      default: return 64'd0;
    endcase
  endfunction

  // Seed extension: signed ops sign-extend from bit SEW-1, others zero-extend.
  function automatic logic [63:0] extend_scalar(input logic [63:0] s, input logic [1:0] op,
                                                input logic [1:0] sew);
    logic sgn;
    sgn = is_signed_op(op);
    case (sew_e'(sew))
      SEW_8:   return {{56{sgn & s[7]}}, s[7:0]};
      SEW_16:  return {{48{sgn & s[15]}}, s[15:0]};
      SEW_32:  return {{32{sgn & s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/vred_feed_seq_if.sv
// Bundle of the request, vs2 read-port and reducer-facing signals of the
// reduction feed sequencer.
//   slave  : the sequencer (consumes req_*/data_*, produces out_*/done)
//   master : the surrounding issue/read logic and reducer view
interface vred_feed_seq_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int OPSEL_WIDTH = 2,
  parameter int SEW_WIDTH   = 2,
  parameter int VL_WIDTH    = 11
);
  logic                   req_valid;
  logic                   req_ready;
  logic [VL_WIDTH-1:0]    req_vl;
  logic [SEW_WIDTH-1:0]   req_sew;
  logic [OPSEL_WIDTH-1:0] req_opSel;
  logic                   req_vm;
  logic [63:0]            req_scalar;

  logic                   data_valid;
  logic                   data_ready;
  logic [DATA_WIDTH-1:0]  data_vec;
  logic [7:0]             data_mask;

  logic [DATA_WIDTH-1:0]  out_vec0;
  logic [DATA_WIDTH-1:0]  out_vec1;
  logic                   out_valid;
  logic                   out_start;
  logic                   out_end;
  logic [OPSEL_WIDTH-1:0] out_opSel;
  logic [SEW_WIDTH-1:0]   out_sew;
  logic                   done;

  modport slave (
    input  req_valid, req_vl, req_sew, req_opSel, req_vm, req_scalar,
    input  data_valid, data_vec, data_mask,
    output req_ready, data_ready,
    output out_vec0, out_vec1, out_valid, out_start, out_end, out_opSel, out_sew, done
  );

  modport master (
    output req_valid, req_vl, req_sew, req_opSel, req_vm, req_scalar,
    output data_valid, data_vec, data_mask,
    input  req_ready, data_ready,
    input  out_vec0, out_vec1, out_valid, out_start, out_end, out_opSel, out_sew, done
  );
endinterface

// File: rtl/vred_elem_fill.sv
// Combinational element fill for one 64-bit vs2 beat.
// Ports: beat_i/mask_i (raw beat and its mask), vm_i (1 = unmasked),
// elem_idx_i (index of element 0 of this beat), vl_i, sew_i, op_i;
// beat_o is the beat with inactive elements replaced by the op identity.
module vred_elem_fill
  import vred_pkg::*;
#(
  parameter int VL_WIDTH = 11
) (
  input  logic [63:0]         beat_i,
  input  logic [7:0]          mask_i,
  input  logic                vm_i,
  input  logic [VL_WIDTH:0]   elem_idx_i,
  input  logic [VL_WIDTH-1:0] vl_i,
  input  logic [1:0]          sew_i,
  input  logic [1:0]          op_i,
  output logic [63:0]         beat_o
);
  logic [63:0] ident;
  logic [2:0]  elem;
  logic [2:0]  byte_in_elem;
  logic        active;

  // Works byte by byte: each byte finds its owning element and its position
  // inside that element, so one loop covers every SEW.
  always_comb begin
    ident        = identity(op_i, sew_i);
    beat_o       = '0;
    elem         = '0;
    byte_in_elem = '0;
    active       = 1'b0;
    for (int b = 0; b < 8; b++) begin
      elem         = 3'(b >> sew_i);
      byte_in_elem = 3'(b) & ((3'd1 << sew_i) - 3'd1);
      active       = ({1'b0, vl_i} > (elem_idx_i + {{(VL_WIDTH-2){1'b0}}, elem}))
                     && (vm_i || mask_i[elem]);
      beat_o[8*b +: 8] = active ? beat_i[8*b +: 8] : ident[{byte_in_elem, 3'b000} +: 8];
    end
  end
endmodule

// File: rtl/vred_feed_seq.sv
// Front-end sequencer for the integer reduction datapath.
// Accepts one reduction request, streams vs2 beats from the read port,
// fills masked/tail elements with the op identity and presents registered
// beats to the reducer (which has no backpressure).
// Ports: clk, rst (sync, active-high), bus (vred_feed_seq_if.slave):
//   req_*  request handshake, data_* vs2 beat handshake,
//   out_*  reducer inputs, done one-cycle retire pulse.
module vred_feed_seq
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int OPSEL_WIDTH = 2,
  parameter int SEW_WIDTH   = 2,
  parameter int VL_WIDTH    = 11
) (
  input logic            clk,
  input logic            rst,
  vred_feed_seq_if.slave bus
);
  state_e                 state_q;
  logic [VL_WIDTH-1:0]    vl_q;
  logic [SEW_WIDTH-1:0]   sew_q;
  logic [OPSEL_WIDTH-1:0] op_q;
  logic                   vm_q;
  logic [DATA_WIDTH-1:0]  seed_q;
  logic [VL_WIDTH:0]      elem_idx_q;
  logic                   first_q;
  logic                   req_ready_q;
  logic                   data_ready_q;
  logic                   out_valid_q;
  logic                   out_start_q;
  logic                   out_end_q;
  logic [DATA_WIDTH-1:0]  out_vec0_q;
  logic [DATA_WIDTH-1:0]  out_vec1_q;
  logic [OPSEL_WIDTH-1:0] out_opsel_q;
  logic [SEW_WIDTH-1:0]   out_sew_q;
  logic                   done_q;

  logic [63:0]            filled_d;
  logic [VL_WIDTH:0]      elem_idx_d;
  logic                   last_beat;

  vred_elem_fill #(.VL_WIDTH(VL_WIDTH)) u_fill (
    .beat_i     (bus.data_vec),
    .mask_i     (bus.data_mask),
    .vm_i       (vm_q),
    .elem_idx_i (elem_idx_q),
    .vl_i       (vl_q),
    .sew_i      (sew_q),
    .op_i       (op_q),
    .beat_o     (filled_d)
  );

  assign elem_idx_d = elem_idx_q + (VL_WIDTH+1)'(epb(sew_q));
  assign last_beat  = elem_idx_d >= {1'b0, vl_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vl_q         <= '0;
      sew_q        <= '0;
      op_q         <= '0;
      vm_q         <= 1'b0;
      seed_q       <= '0;
      elem_idx_q   <= '0;
      first_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_start_q  <= 1'b0;
      out_end_q    <= 1'b0;
      out_vec0_q   <= '0;
      out_vec1_q   <= '0;
      out_opsel_q  <= '0;
      out_sew_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      out_opsel_q <= '0;
      out_sew_q   <= '0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // req_ready is held low for the cycle in which done pulses, so a
          // new request can only land after the previous one has retired.
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            vl_q        <= bus.req_vl;
            sew_q       <= bus.req_sew;
            op_q        <= bus.req_opSel;
            vm_q        <= bus.req_vm;
            seed_q      <= extend_scalar(bus.req_scalar, bus.req_opSel, bus.req_sew);
            elem_idx_q  <= '0;
            first_q     <= 1'b1;
            req_ready_q <= 1'b0;
            if (bus.req_vl == '0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q      <= ST_STREAM;
              data_ready_q <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (bus.data_valid && data_ready_q) begin
            out_valid_q <= 1'b1;
            out_start_q <= first_q;
            out_vec0_q  <= filled_d;
            out_vec1_q  <= seed_q;
            out_opsel_q <= op_q;
            out_sew_q   <= sew_q;
            first_q     <= 1'b0;
            elem_idx_q  <= elem_idx_d;
            if (last_beat) begin
              out_end_q    <= 1'b1;
              data_ready_q <= 1'b0;
              state_q      <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.data_ready = data_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_start  = out_start_q;
  assign bus.out_end    = out_end_q;
  assign bus.out_vec0   = out_vec0_q;
  assign bus.out_vec1   = out_vec1_q;
  assign bus.out_opSel  = out_opsel_q;
  assign bus.out_sew    = out_sew_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_vred_feed_seq.sv
// Self-checking bench for vred_feed_seq: constant single-beat vectors, a
// reference model for multi-beat requests, and a scoreboard of expected
// reducer beats.
module tb_vred_feed_seq;
  import vred_pkg::*;

  typedef struct {
    logic [63:0] vec0;
    logic [63:0] vec1;
    logic        start;
    logic        fin;
    logic [1:0]  op;
    logic [1:0]  sew;
  } exp_t;

  typedef struct {
    string       name;
    int          vl;
    int          sew;
    logic [1:0]  op;
    logic        vm;
    logic [63:0] scalar;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] exp_vec0;
    logic [63:0] exp_vec1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vred_feed_seq_if bus ();
  vred_feed_seq dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_pass = 0;
  int   n_total = 0;
  int   beat_cnt = 0;
  int   end_cnt = 0;
  int   done_cnt = 0;
  int   dr_cnt = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.data_ready === 1'b1) dr_cnt++;
    if (bus.out_valid === 1'b1) begin
      beat_cnt++;
      if (bus.out_end === 1'b1) end_cnt++;
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_vec0", bus.out_vec0, e.vec0);
        check("out_vec1", bus.out_vec1, e.vec1);
        check("out_start", 64'(bus.out_start), 64'(e.start));
        check("out_end", 64'(bus.out_end), 64'(e.fin));
        check("out_opSel", 64'(bus.out_opSel), 64'(e.op));
        check("out_sew", 64'(bus.out_sew), 64'(e.sew));
      end
    end else if (bus.out_valid === 1'b0) begin
      check("idle_opsel_sew", 64'({bus.out_opSel, bus.out_sew}), 64'd0);
    end
  end

  function automatic logic [63:0] model_fill(input logic [63:0] data, input logic [7:0] mask,
                                             input logic vm, input int idx, input int vl,
                                             input int sew, input logic [1:0] op);
    int          w = 8 << sew;
    int          n = 64 / w;
    logic [63:0] idn = '0;
    logic [63:0] res = data;
    if (op == OP_MAX) idn[w-1] = 1'b1;
    if (op == OP_MIN) for (int k = 0; k < w - 1; k++) idn[k] = 1'b1;
    for (int i = 0; i < n; i++)
      if (!(((idx + i) < vl) && (vm || mask[i])))
        for (int k = 0; k < w; k++) res[i*w+k] = idn[k];
    return res;
  endfunction

  function automatic logic [63:0] model_seed(input logic [63:0] s, input int sew,
                                             input logic [1:0] op);
    int          w = 8 << sew;
    logic [63:0] res;
    for (int k = 0; k < 64; k++)
      res[k] = (k < w) ? s[k] : (((op == OP_MAX) || (op == OP_MIN)) ? s[w-1] : 1'b0);
    return res;
  endfunction

  // All driver tasks are entered just after a rising edge.
  task automatic send_req(input int vl, input int sew, input logic [1:0] op, input logic vm,
                          input logic [63:0] scalar);
    int guard = 0;
    bus.req_vl     = 11'(vl);
    bus.req_sew    = 2'(sew);
    bus.req_opSel  = op;
    bus.req_vm     = vm;
    bus.req_scalar = scalar;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("req_accept", 64'(bus.req_ready === 1'b1), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] data, input logic [7:0] mask, input exp_t e);
    int guard = 0;
    bus.data_vec   = data;
    bus.data_mask  = mask;
    bus.data_valid = 1'b1;
    @(negedge clk);
    while (bus.data_ready !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("data_accept", 64'(bus.data_ready === 1'b1), 64'd1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  // Entered right after the last handshake edge (or request edge for vl=0);
  // done is expected on the second falling edge from there.
  task automatic wait_done(input string name, input int exp_k);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done !== 1'b1 && k < 40);
    check({name, "_done_latency"}, 64'(k), 64'(exp_k));
    check({name, "_ready_low_at_done"}, 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t make_exp(input logic [63:0] d, input logic [7:0] m, input logic vm,
                                    input int idx, input int vl, input int sew,
                                    input logic [1:0] op, input logic [63:0] scalar,
                                    input logic start, input logic fin);
    exp_t x;
    x.vec0  = model_fill(d, m, vm, idx, vl, sew, op);
    x.vec1  = model_seed(scalar, sew, op);
    x.start = start;
    x.fin   = fin;
    x.op    = op;
    x.sew   = 2'(sew);
    return x;
  endfunction

  task automatic run_stream(input string name, input int vl, input int sew, input logic [1:0] op,
                            input logic vm, input logic [63:0] scalar, input int gap_after,
                            input int gap_len);
    int          e  = 8 >> sew;
    int          nb = (vl + e - 1) / e;
    logic [63:0] d;
    logic [7:0]  m;
    send_req(vl, sew, op, vm, scalar);
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      m = 8'($urandom);
      send_beat(d, m, make_exp(d, m, vm, b * e, vl, sew, op, scalar, b == 0, b == nb - 1));
      if (b == gap_after && b != nb - 1) repeat (gap_len) @(posedge clk);
      if (b == gap_after && b != nb - 1 && gap_len > 0) #1;
    end
    wait_done(name, 2);
  endtask

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b0, e0, d0, r0;
    logic [63:0] d;
    exp_t        x;

    tbl[0] = '{"sum8_full",  8, 0, OP_SUM,  1'b1, 64'h5, 64'h0807060504030201, 8'hFF,
               64'h0807060504030201, 64'h5};
    tbl[1] = '{"max32_mask", 2, 2, OP_MAX,  1'b0, 64'hFFFF_FFFE, 64'h00000003_00000009, 8'h01,
               64'h80000000_00000009, 64'hFFFFFFFF_FFFFFFFE};
    tbl[2] = '{"min8_tail",  3, 0, OP_MIN,  1'b1, 64'h80, 64'h1122334455667788, 8'h00,
               64'h7F7F7F7F7F667788, 64'hFFFFFFFF_FFFFFF80};
    tbl[3] = '{"maxu16_msk", 4, 1, OP_MAXU, 1'b0, 64'h1234_F00D, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0A,
               64'hAAAA_0000_CCCC_0000, 64'h0000_0000_0000_F00D};
    tbl[4] = '{"sum64_msk",  1, 3, OP_SUM,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEADBEEF, 8'hFE,
               64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{"max64_act",  1, 3, OP_MAX,  1'b1, 64'h8000_0000_0000_0000, 64'h123, 8'h00,
               64'h123, 64'h8000_0000_0000_0000};
    tbl[6] = '{"min32_tail", 1, 2, OP_MIN,  1'b1, 64'h7, 64'h11111111_22222222, 8'h00,
               64'h7FFFFFFF_22222222, 64'h7};
    tbl[7] = '{"max16_mix",  3, 1, OP_MAX,  1'b0, 64'h8001, 64'h4444_3333_2222_1111, 8'h06,
               64'h8000_3333_2222_8000, 64'hFFFF_FFFF_FFFF_8001};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_vl     = '0;
    bus.req_sew    = '0;
    bus.req_opSel  = '0;
    bus.req_vm     = 1'b0;
    bus.req_scalar = '0;
    bus.data_valid = 1'b0;
    bus.data_vec   = '0;
    bus.data_mask  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_data_ready", 64'(bus.data_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_start_end", 64'({bus.out_start, bus.out_end}), 64'd0);
    check("rst_vec0", bus.out_vec0, 64'd0);
    @(posedge clk);
    #1;

    // Single-beat constant vectors
    for (int i = 0; i < 8; i++) begin
      x.vec0  = tbl[i].exp_vec0;
      x.vec1  = tbl[i].exp_vec1;
      x.start = 1'b1;
      x.fin   = 1'b1;
      x.op    = tbl[i].op;
      x.sew   = 2'(tbl[i].sew);
      send_req(tbl[i].vl, tbl[i].sew, tbl[i].op, tbl[i].vm, tbl[i].scalar);
      send_beat(tbl[i].data, tbl[i].mask, x);
      wait_done(tbl[i].name, 2);
    end

    // MIN 16b, vl=6: two beats, second beat tail-filled
    run_stream("min16_2beat", 6, 1, OP_MIN, 1'b1, 64'hFFFF_0042, -1, 0);

    // vl = 0
    b0 = beat_cnt;
    r0 = dr_cnt;
    send_req(0, 0, OP_SUM, 1'b1, 64'h0);
    wait_done("vl0", 2);
    check("vl0_no_beats", 64'(beat_cnt - b0), 64'd0);
    check("vl0_no_data_ready", 64'(dr_cnt - r0), 64'd0);
    @(negedge clk);
    check("vl0_ready_back", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Stall after beat 2, then reset after beat 3
    send_req(32, 0, OP_SUM, 1'b1, 64'h3);
    for (int b = 0; b < 2; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, 8'h00, make_exp(d, 8'h00, 1'b1, b * 8, 32, 0, OP_SUM, 64'h3, b == 0, 1'b0));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_elem_idx", 64'(dut.elem_idx_q), 64'd16);
      if (c > 0) check("stall_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    d = {$urandom, $urandom};
    send_beat(d, 8'h00, make_exp(d, 8'h00, 1'b1, 16, 32, 0, OP_SUM, 64'h3, 1'b0, 1'b0));
    e0 = end_cnt;
    d0 = done_cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_req_ready", 64'(bus.req_ready), 64'd1);
    check("rstmid_data_ready", 64'(bus.data_ready), 64'd0);
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("rstmid_no_end", 64'(end_cnt - e0), 64'd0);
    check("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk);
    #1;

    // Max vl, then an immediate single-beat request
    b0 = beat_cnt;
    e0 = end_cnt;
    run_stream("maxvl", 1024, 0, OP_MAXU, 1'b0, 64'hAB, -1, 0);
    check("maxvl_beats", 64'(beat_cnt - b0), 64'd128);
    check("maxvl_ends", 64'(end_cnt - e0), 64'd1);
    check("maxvl_elem_idx", 64'(dut.elem_idx_q), 64'd1024);
    run_stream("after_max", 5, 0, OP_SUM, 1'b1, 64'h1F, -1, 0);

    // Random mix with occasional stalls
    for (int i = 0; i < 8; i++) begin
      run_stream("rand", $urandom_range(1, 40), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 2),
                 $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
